// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared scan codes, 7-seg table and count widths for the parking controller
package parking_pkg;

  localparam int REM_W = 4;
  localparam int TOT_W = 5;

  localparam logic [7:0] KEY_0    = 8'h45;
  localparam logic [7:0] KEY_1    = 8'h16;
  localparam logic [7:0] KEY_2    = 8'h1E;
  localparam logic [7:0] KEY_3    = 8'h26;
  localparam logic [7:0] KEY_4    = 8'h25;
  localparam logic [7:0] KEY_5    = 8'h2E;
  localparam logic [7:0] KEY_6    = 8'h36;
  localparam logic [7:0] KEY_7    = 8'h3D;
  localparam logic [7:0] KEY_8    = 8'h3E;
  localparam logic [7:0] KEY_9    = 8'h46;
  localparam logic [7:0] KEY_ESC  = 8'h76;
  localparam logic [7:0] KEY_EXIT = 8'h24;

  // Active-high segments, bit6..bit0 = g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // True for any of the ten numeric scan codes
  function automatic logic is_digit_code(input logic [7:0] code);
    logic hit;
    case (code)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: hit = 1'b1;
      default:                           hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/parking_controller_seg7_decoder.sv
// rtl/parking_controller_seg7_decoder.sv - BCD digit to active-high 7-segment pattern
module seg7_decoder
  import parking_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; non-decimal inputs blank the digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/parking_controller.sv
// rtl/parking_controller.sv - two-floor parking access controller with keyboard password entry
module parking_controller
  import parking_pkg::*;
#(
  parameter int         FLOOR_CAP = 9,
  parameter logic [7:0] PW0       = 8'h16,
  parameter logic [7:0] PW1       = 8'h16,
  parameter logic [7:0] PW2       = 8'h26,
  parameter logic [7:0] ESC_CODE  = 8'h76,
  parameter logic [7:0] EXIT_CODE = 8'h24,
  parameter int         LED_HOLD  = 20
) (
  input  logic       clk,
  input  logic       power,
  input  logic       flr,
  input  logic [7:0] key1_code,
  input  logic       key1_on,
  output logic [6:0] first_rem_BCD,
  output logic [6:0] second_rem_BCD,
  output logic [6:0] tot_rem_BCD_left,
  output logic [6:0] tot_rem_BCD_right,
  output logic       red_power_led,
  output logic       red_wrong_led,
  output logic       green_led
);

  localparam int TW = (LED_HOLD < 2) ? 1 : $clog2(LED_HOLD + 1);
  localparam logic [TW-1:0]    HOLD = TW'(LED_HOLD);
  localparam logic [REM_W-1:0] CAP  = REM_W'(FLOOR_CAP);

  logic [REM_W-1:0] rem1_q, rem1_d, rem2_q, rem2_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [7:0]       slot0_q, slot0_d, slot1_q, slot1_d;
  logic             green_q, green_d, red_q, red_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             key_hist_q, key_hist_d;

  logic             press;
  logic [REM_W-1:0] rem_sel;

  // State registers, all cleared the instant power drops
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      rem1_q     <= CAP;
      rem2_q     <= CAP;
      cnt_q      <= 2'd0;
      slot0_q    <= 8'h00;
      slot1_q    <= 8'h00;
      green_q    <= 1'b0;
      red_q      <= 1'b0;
      timer_q    <= '0;
      key_hist_q <= 1'b0;
    end else begin
      rem1_q     <= rem1_d;
      rem2_q     <= rem2_d;
      cnt_q      <= cnt_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      green_q    <= green_d;
      red_q      <= red_d;
      timer_q    <= timer_d;
      key_hist_q <= key_hist_d;
    end
  end

  // Edge-detected key handling, password evaluation and LED hold timing
  always_comb begin
    rem1_d     = rem1_q;
    rem2_d     = rem2_q;
    cnt_d      = cnt_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    green_d    = green_q;
    red_d      = red_q;
    timer_d    = timer_q;
    key_hist_d = key1_on;

    press   = key1_on & ~key_hist_q;
    rem_sel = flr ? rem2_q : rem1_q;

    // Hold timer runs down first; an accepted press below overrides it
    if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
      if (timer_q == {{(TW-1){1'b0}}, 1'b1}) begin
        green_d = 1'b0;
        red_d   = 1'b0;
      end
    end

    if (press) begin
      if (is_digit_code(key1_code)) begin
        green_d = 1'b0;
        red_d   = 1'b0;
        timer_d = '0;
        case (cnt_q)
          2'd0: begin
            slot0_d = key1_code;
            cnt_d   = 2'd1;
          end
          2'd1: begin
            slot1_d = key1_code;
            cnt_d   = 2'd2;
          end
          default: begin
            // Third digit: evaluate on the same edge it arrives
            cnt_d   = 2'd0;
            timer_d = HOLD;
            if (slot0_q == PW0 && slot1_q == PW1 && key1_code == PW2 &&
                rem_sel != '0) begin
              green_d = 1'b1;
              if (flr) rem2_d = rem2_q - 1'b1;
              else     rem1_d = rem1_q - 1'b1;
            end else begin
              red_d = 1'b1;
            end
          end
        endcase
      end else if (key1_code == ESC_CODE) begin
        cnt_d   = 2'd0;
        slot0_d = 8'h00;
        slot1_d = 8'h00;
        green_d = 1'b0;
        red_d   = 1'b0;
        timer_d = '0;
      end else if (key1_code == EXIT_CODE) begin
        green_d = 1'b0;
        red_d   = 1'b0;
        timer_d = '0;
        if (rem_sel < CAP) begin
          if (flr) rem2_d = rem2_q + 1'b1;
          else     rem1_d = rem1_q + 1'b1;
        end
      end
    end
  end

  logic [TOT_W-1:0] tot, tot_minus_ten;
  logic [3:0]       tot_tens, tot_ones;

  // Split the 0..18 total into tens and ones digits
  always_comb begin
    tot           = {1'b0, rem1_q} + {1'b0, rem2_q};
    tot_minus_ten = tot - TOT_W'(10);
    if (tot >= TOT_W'(10)) begin
      tot_tens = 4'd1;
      tot_ones = tot_minus_ten[3:0];
    end else begin
      tot_tens = 4'd0;
      tot_ones = tot[3:0];
    end
  end

  seg7_decoder u_seg_first  (.bcd(rem1_q),   .seg(first_rem_BCD));
  seg7_decoder u_seg_second (.bcd(rem2_q),   .seg(second_rem_BCD));
  seg7_decoder u_seg_left   (.bcd(tot_tens), .seg(tot_rem_BCD_left));
  seg7_decoder u_seg_right  (.bcd(tot_ones), .seg(tot_rem_BCD_right));

  assign red_power_led = ~power;
  assign red_wrong_led = red_q;
  assign green_led     = green_q;

endmodule

// File: tb/tb_parking_controller.sv
// tb/tb_parking_controller.sv - directed self-checking bench for parking_controller
module tb_parking_controller;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S6 = 7'b1111101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1101111;

  logic       clk = 1'b0;
  logic       power;
  logic       flr;
  logic [7:0] key1_code;
  logic       key1_on;
  logic [6:0] first_rem_BCD, second_rem_BCD, tot_rem_BCD_left, tot_rem_BCD_right;
  logic       red_power_led, red_wrong_led, green_led;

  int vecs = 0;
  int errs = 0;

  parking_controller dut (
    .clk               (clk),
    .power             (power),
    .flr               (flr),
    .key1_code         (key1_code),
    .key1_on           (key1_on),
    .first_rem_BCD     (first_rem_BCD),
    .second_rem_BCD    (second_rem_BCD),
    .tot_rem_BCD_left  (tot_rem_BCD_left),
    .tot_rem_BCD_right (tot_rem_BCD_right),
    .red_power_led     (red_power_led),
    .red_wrong_led     (red_wrong_led),
    .green_led         (green_led)
  );

  always #5 clk = ~clk;

  // Press a key for 10 cycles, then watch 30 cycles; returns how many samples each LED was lit
  task automatic tap(input logic [7:0] code, output int g_cnt, output int r_cnt);
    int both;
    @(negedge clk);
    key1_code = code;
    key1_on   = 1'b1;
    g_cnt = 0;
    r_cnt = 0;
    both  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 9) key1_on = 1'b0;
      if (green_led === 1'b1) g_cnt++;
      if (red_wrong_led === 1'b1) r_cnt++;
      if (green_led === 1'b1 && red_wrong_led === 1'b1) both++;
    end
    vecs++;
    if (both !== 0) begin
      errs++;
      $display("FAIL led_exclusive key=%h both_lit_samples=%0d expected 0", code, both);
    end
  endtask

  task automatic check_disp(input string tag, input logic [6:0] e1, input logic [6:0] e2,
                            input logic [6:0] el, input logic [6:0] er);
    vecs++;
    if ({first_rem_BCD, second_rem_BCD, tot_rem_BCD_left, tot_rem_BCD_right} !== {e1, e2, el, er}) begin
      errs++;
      $display("FAIL %s displays got %b %b %b %b expected %b %b %b %b", tag,
               first_rem_BCD, second_rem_BCD, tot_rem_BCD_left, tot_rem_BCD_right, e1, e2, el, er);
    end
  endtask

  task automatic check_leds(input string tag, input int g, input int r, input int eg, input int er);
    vecs++;
    if (g !== eg || r !== er) begin
      errs++;
      $display("FAIL %s green=%0d red=%0d expected green=%0d red=%0d", tag, g, r, eg, er);
    end
  endtask

  task automatic test_reset();
    power = 1'b0;
    flr = 1'b0;
    key1_code = 8'h00;
    key1_on = 1'b0;
    #100;
    vecs++;
    if (red_power_led !== 1'b1) begin
      errs++;
      $display("FAIL reset_power_led got %b expected 1", red_power_led);
    end
    vecs++;
    if (green_led !== 1'b0 || red_wrong_led !== 1'b0) begin
      errs++;
      $display("FAIL reset_leds got g=%b r=%b expected 0 0", green_led, red_wrong_led);
    end
    check_disp("reset", S9, S9, S1, S8);
    @(negedge clk);
    power = 1'b1;
    @(negedge clk);
    vecs++;
    if (red_power_led !== 1'b0) begin
      errs++;
      $display("FAIL release_power_led got %b expected 0", red_power_led);
    end
    check_disp("after_release", S9, S9, S1, S8);
  endtask

  task automatic test_grant();
    int g, r;
    flr = 1'b0;
    tap(8'h16, g, r); check_leds("grant_d1", g, r, 0, 0);
    tap(8'h16, g, r); check_leds("grant_d2", g, r, 0, 0);
    tap(8'h26, g, r); check_leds("grant_d3", g, r, 20, 0);
    check_disp("grant", S8, S9, S1, S7);
  endtask

  task automatic test_wrong();
    int g, r;
    tap(8'h76, g, r); check_leds("wrong_esc", g, r, 0, 0);
    tap(8'h26, g, r);
    tap(8'h26, g, r); check_leds("wrong_d2", g, r, 0, 0);
    tap(8'h26, g, r); check_leds("wrong_d3", g, r, 0, 20);
    check_disp("wrong", S8, S9, S1, S7);
    tap(8'h26, g, r);
    tap(8'h26, g, r);
    tap(8'h26, g, r); check_leds("wrong_again", g, r, 0, 20);
    check_disp("wrong_again", S8, S9, S1, S7);
  endtask

  task automatic test_esc_discard();
    int g, r;
    tap(8'h16, g, r);
    tap(8'h16, g, r);
    tap(8'h76, g, r);
    tap(8'h16, g, r);
    tap(8'h16, g, r); check_leds("esc_d2", g, r, 0, 0);
    tap(8'h26, g, r); check_leds("esc_d3", g, r, 20, 0);
    check_disp("esc", S7, S9, S1, S6);
  endtask

  task automatic test_fill_floor2();
    int g, r;
    flr = 1'b1;
    for (int n = 0; n < 9; n++) begin
      tap(8'h16, g, r);
      tap(8'h16, g, r);
      tap(8'h26, g, r); check_leds("fill_entry", g, r, 20, 0);
    end
    check_disp("fill_full", S7, S0, S0, S7);
    tap(8'h16, g, r);
    tap(8'h16, g, r);
    tap(8'h26, g, r); check_leds("fill_tenth", g, r, 0, 20);
    check_disp("fill_tenth", S7, S0, S0, S7);
    tap(8'h24, g, r); check_leds("exit_f2", g, r, 0, 0);
    check_disp("exit_f2", S7, S1, S0, S8);
    flr = 1'b0;
    tap(8'h24, g, r);
    tap(8'h24, g, r);
    check_disp("exit_f1_cap", S9, S1, S1, S0);
    tap(8'h24, g, r);
    check_disp("exit_f1_sat", S9, S1, S1, S0);
  endtask

  task automatic test_power_drop();
    int g, r;
    flr = 1'b1;
    tap(8'h16, g, r);
    tap(8'h16, g, r);
    @(negedge clk);
    #2 power = 1'b0;
    #1;
    vecs++;
    if (red_power_led !== 1'b1 || green_led !== 1'b0 || red_wrong_led !== 1'b0) begin
      errs++;
      $display("FAIL drop_leds got pwr=%b g=%b r=%b expected 1 0 0",
               red_power_led, green_led, red_wrong_led);
    end
    check_disp("drop", S9, S9, S1, S8);
    @(negedge clk);
    power = 1'b1;
    tap(8'h26, g, r); check_leds("drop_single", g, r, 0, 0);
    check_disp("drop_single", S9, S9, S1, S8);
    tap(8'h16, g, r);
    tap(8'h16, g, r); check_leds("drop_restart", g, r, 0, 20);
  endtask

  initial begin
    test_reset();
    test_grant();
    test_wrong();
    test_esc_discard();
    test_fill_floor2();
    test_power_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/parking_controller.md
Name: parking_controller

Overview:
Two-floor parking-lot access controller driven by a PS/2-style keyboard.
- A driver types a 3-digit password. A correct code admits one car to the floor chosen by flr: that floor's free-space count decrements and the green LED lights.
- A wrong code, or a full floor, lights the red "wrong" LED.
- Free spaces per floor and in total are shown on four 7-segment digits.
- The block sits between the keyboard scan-code receiver and the board LEDs/displays.

Parameters:
FLOOR_CAP, 9, spaces per floor (1..9)
PW0, 8'h16, first password scan code ('1')
PW1, 8'h16, second password scan code ('1')
PW2, 8'h26, third password scan code ('3')
ESC_CODE, 8'h76, clears partial entry
EXIT_CODE, 8'h24, car leaves floor flr ('E')
LED_HOLD, 20, cycles green/red_wrong stay lit

Ports:
clk  in  1  system clock, rising edge
power  in  1  asynchronous active-low reset (0 = power off / reset)
flr  in  1  floor select: 0 = first, 1 = second
key1_code  in  8  scan code of current key
key1_on  in  1  high while key pressed; a press is its 0->1 transition
first_rem_BCD  out  7  7-seg of free spaces, floor 1
second_rem_BCD  out  7  7-seg of free spaces, floor 2
tot_rem_BCD_left  out  7  7-seg tens digit of total free spaces
tot_rem_BCD_right  out  7  7-seg ones digit of total free spaces
red_power_led  out  1  lit while power is low
red_wrong_led  out  1  wrong password / floor full indication
green_led  out  1  access granted indication

Behaviour:
- Reset (power=0, async):
  - rem1 = rem2 = FLOOR_CAP; digit counter = 0.
  - green_led = red_wrong_led = 0; hold timer = 0; key1_on history register = 0.
  - red_power_led = ~power, combinational.
- 7-seg encoding is active-high, bit6..bit0 = g,f,e,d,c,b,a. Codes:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Displays are combinational from the registered counts.
  - total = rem1 + rem2 (0..18); left = total/10, right = total%10.
  - Reset display with FLOOR_CAP=9: 9, 9, 1, 8.
- Press detection: key1_on_d registered each cycle. A press is key1_on & ~key1_on_d, acted on at that same clock edge. Holding a key yields exactly one press.
- Press handling by key1_code:
  - Digit scan code (16,1E,26,25,2E,36,3D,3E,46,45): stored in slot[digit counter], counter increments.
  - ESC_CODE: counter := 0, stored digits discarded, LEDs cleared.
  - EXIT_CODE: if the selected floor's rem < FLOOR_CAP then rem += 1, else ignored. Counter unchanged.
  - Any other code: ignored.
- Any accepted press clears green_led and red_wrong_led.
- Third-digit evaluation happens on the same edge as the third digit is stored:
  - Counter := 0.
  - Sequence == PW0,PW1,PW2 and selected floor rem > 0: that rem -= 1, green_led := 1.
  - Otherwise (mismatch, or floor full): red_wrong_led := 1, counts unchanged.
  - flr is sampled at this edge.
- LED hold: on assertion the timer loads LED_HOLD. The timer decrements each cycle and the LED clears at 0, or earlier on the next accepted press. green_led and red_wrong_led are never both 1.
- Counts saturate: never below 0, never above FLOOR_CAP.
- Power dropping mid-entry or mid-hold restores the full reset state immediately.

Decomposition:
- Package parking_pkg holds:
  - scan-code constants for digits 0-9, ESC and EXIT;
  - the 7-seg code table constants;
  - the counter width (4 bits per floor, 5 bits for total).
- One sub-module, seg7_decoder: 4-bit BCD in, 7-bit segments out, purely combinational. Instantiated four times.

Test Plan:
- Hold power=0 for 100 ns, then release -> red_power_led=1 during reset then 0; leds 0; displays 9,9 and total 1,8.
- Keys 16,16,26 with flr=0, each key1_on held 10 cycles -> on the third press green_led=1 for 20 cycles; first_rem=8 (1111111); total 1,7 (0000110,0000111).
- Key 76 (Esc), then 26,26,26 -> red_wrong_led=1 after the third press, counts unchanged; a further 26,26,26 -> red_wrong_led again.
- Keys 16, 16, 76, then 16,16,26 -> Esc discards the partial entry; the second sequence grants access (green).
- Nine correct entries with flr=1 -> second_rem reaches 0; a tenth correct entry -> red_wrong_led, second_rem stays 0. Then EXIT_CODE with flr=1 -> second_rem=1.
- Drop power mid-entry after two digits -> immediate reset; then 26 alone does not evaluate (counter restarted at 0).
